digit_result_filter: RTL

//  Temporal filter between the digit-recognition VIP stage and the 6-digit
//  BCD seven-segment driver. Samples the raw 24-bit BCD result once per LCD

---
 rtl/digit_result_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/digit_result_filter.sv
// digit_result_filter
//   Temporal filter between the digit-recognition stage and the 6-digit BCD
//   seven-segment driver. Once per LCD frame, at the end of the frame, it
//   samples the raw BCD result. It commits a value to the display only after
//   STABLE_FRAMES consecutive identical valid frames. It blanks the display
//   after TIMEOUT_FRAMES consecutive invalid frames.
//
// Ports
//   i_clk          LCD pixel clock
//   i_rst          asynchronous reset, active-high
//   i_frame_vsync  frame sync, same clock domain; active level is VS_ACTIVE
//   i_digit_in     raw recognised digits, DW/4 BCD nibbles (4'hF = blank digit)
//   o_digit_out    filtered digits to the seven-segment driver
//   o_digit_update 1-clk pulse when o_digit_out changes value
//   o_stable       1 = o_digit_out is backed by the current candidate
module digit_result_filter #(
  parameter int   DW             = 24,
  parameter int   STABLE_FRAMES  = 3,
  parameter int   TIMEOUT_FRAMES = 60,
  parameter logic VS_ACTIVE      = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_vsync,
  input  logic [DW-1:0] i_digit_in,
  output logic [DW-1:0] o_digit_out,
  output logic          o_digit_update,
  output logic          o_stable
);

  localparam int NIB  = DW / 4;
  localparam int MAXF = (STABLE_FRAMES > TIMEOUT_FRAMES) ? STABLE_FRAMES : TIMEOUT_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  localparam logic [CW-1:0] STABLE_C  = CW'(STABLE_FRAMES);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_FRAMES);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [DW-1:0] BLANK     = '1;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic          r_vs_d;
  logic [DW-1:0] r_cand, r_out;
  logic [CW-1:0] r_match, r_miss;
  logic [1:0]    r_state;
  logic          r_update;

  logic          w_frame_end;
  logic          w_any_digit, w_all_legal, w_valid;
  logic [DW-1:0] w_cand_d, w_out_d;
  logic [CW-1:0] w_match_d, w_miss_d;
  logic [1:0]    w_state_d;
  logic          w_update_d;

  assign w_frame_end = (r_vs_d == VS_ACTIVE) && (i_frame_vsync != VS_ACTIVE);

  // A sample is valid when every nibble is BCD or blank and at least one is not blank.
  always_comb begin
    w_any_digit = 1'b0;
    w_all_legal = 1'b1;
    for (int i = 0; i < NIB; i++) begin
      if (i_digit_in[4*i +: 4] != 4'hF) begin
        w_any_digit = 1'b1;
        if (i_digit_in[4*i +: 4] > 4'd9) w_all_legal = 1'b0;
      end
    end
    w_valid = w_any_digit && w_all_legal;
  end

  always_comb begin
    w_cand_d   = r_cand;
    w_out_d    = r_out;
    w_match_d  = r_match;
    w_miss_d   = r_miss;
    w_state_d  = r_state;
    w_update_d = 1'b0;
    if (w_frame_end) begin
      if (!w_valid) begin
        w_match_d = '0;
        w_state_d = EMPTY;
        // Blank only on the frame the miss count first reaches the timeout.
        if (r_miss < TIMEOUT_C) begin
          w_miss_d = r_miss + ONE_C;
          if (w_miss_d == TIMEOUT_C) w_out_d = BLANK;
        end
      end else if (i_digit_in == r_cand) begin
        w_miss_d  = '0;
        w_match_d = (r_match < STABLE_C) ? r_match + ONE_C : r_match;
        if (w_match_d == STABLE_C) begin
          w_out_d   = r_cand;
          w_state_d = LOCKED;
        end else begin
          w_state_d = TRACK;
        end
      end else begin
        w_cand_d  = i_digit_in;
        w_match_d = ONE_C;
        w_miss_d  = '0;
        if (STABLE_C == ONE_C) begin
          w_out_d   = i_digit_in;
          w_state_d = LOCKED;
        end else begin
          w_state_d = TRACK;
        end
      end
      w_update_d = (w_out_d != r_out);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs_d   <= ~VS_ACTIVE;
      r_cand   <= BLANK;
      r_out    <= BLANK;
      r_match  <= '0;
      r_miss   <= '0;
      r_state  <= EMPTY;
      r_update <= 1'b0;
    end else begin
      r_vs_d   <= i_frame_vsync;
      r_cand   <= w_cand_d;
      r_out    <= w_out_d;
      r_match  <= w_match_d;
      r_miss   <= w_miss_d;
      r_state  <= w_state_d;
      r_update <= w_update_d;
    end
  end

  assign o_digit_out    = r_out;
  assign o_digit_update = r_update;
  assign o_stable       = (r_state == LOCKED);

endmodule
